memory_stage: RTL
=================

# memory_stage

Memory stage of the pipelined processor: consumes the EX/MEM buffer fields produced by the execution stage, performs data-memory load/store and stack push/pop, and owns the stack pointer. It sequences 32-bit PC pushes/pops (CALL/INT/RET/RTI) as multi-beat 16-bit memory transfers, stalling the front of the pipe meanwhile. It returns restored flags to the execution stage and drives the MEM/WB buffer.

## Interface
- ADDR_W, 12, data-memory word-address width.
- SP_INIT, 2**ADDR_W-1, stack pointer reset value (stack grows downward).
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Data  in  32  EX/MEM data (store data in [15:0], PC for PC pushes).
- Address  in  32  EX/MEM address; low ADDR_W bits used.
- MR, MW, WB, SP, SPOP, JWSP, Stack_PC, Stack_Flags  in  1 each  EX/MEM control bits.
- WB_Address  in  3  destination register.
- Final_Flags  in  3  NF|CF|ZF from execute.
- Mem_RData  in  16  data-memory read data (combinational read).
- Mem_Addr  out  ADDR_W  memory address.
- Mem_WData  out  16  memory write data.
- Mem_WE  out  1  memory write enable (written at clock edge).
- Stall  out  1  freeze IF..EX/MEM buffers.
- WB_Out, WB_Address_Out, WB_Data  out  1/3/16  MEM/WB fields, registered.
- PC_From_Memory  out  32  popped PC, registered.
- PC_Load  out  1  one-cycle pulse: PC_From_Memory valid.
- Flags_From_Memory  out  3  popped flags, registered.
- MEM_Stack_Flags  out  1  one-cycle pulse: Flags_From_Memory valid.
- SP_Value  out  ADDR_W  current stack pointer (debug).

## Operation
- Op classes: push = SP&!SPOP&MW; pop = SP&SPOP&MR; load = !SP&MR; store = !SP&MW; MR&MW without SP treated as store.
- Single word: load/store at Address[ADDR_W-1:0]; push writes Data[15:0] at SP, SP←SP-1; pop reads SP+1, SP←SP+1.
- Multi-beat (Stack_PC=1): beat count N = 2 + Stack_Flags.
  - Push order: PC[31:16] at SP, PC[15:0] at SP-1, then {13'b0,Final_Flags} at SP-2 if Stack_Flags; SP decremented per beat.
  - Pop order reversed: flags at SP+1 (if Stack_Flags), PC[15:0], PC[31:16]; SP incremented per beat.
- FSM: IDLE → BEAT1 → BEAT2 (BEAT2 only when N=3) → IDLE. IDLE issues beat 0 directly from EX/MEM inputs and latches the command; later beats use latched command.
- Stall = (IDLE & Stack_PC & (push|pop)) | (state≠IDLE & not last beat). Upstream holds EX/MEM stable while Stall=1.
- WB_Data = Mem_RData for load/single pop, else Data[15:0]. WB_Out forced 0 for Stack_PC ops.
- SP arithmetic modulo 2**ADDR_W (wraps silently).

## Timing
- Reset: SP=SP_INIT, state IDLE, all registered outputs 0, Stall 0.
- Mem_Addr/Mem_WData/Mem_WE combinational from state/inputs; write commits at edge.
- WB_* latency 1 cycle after the accepting edge.
- Single-word op: 1 cycle, no stall. Push of N beats: N cycles, Stall high first N-1.
- Pop of N beats: PC_Load pulses the cycle after the last beat; MEM_Stack_Flags pulses the cycle after the flags beat.
- Reset mid-burst: return to IDLE immediately; already-written words stay in memory; SP reverts to SP_INIT; no PC_Load.
- Push then pop in consecutive instructions: pop sees updated SP (no bypass hazard; SP is internal).

## Structure
- Package memory_stage_pkg: state enum (IDLE, BEAT1, BEAT2), op-class enum, SP_INIT default, flags-word layout constant.
- One sub-module: sp_register (SP storage, ±1 update, wrap, reset to SP_INIT).

## Test plan
- Reset, then store Data=16'h00AB at Address=5, load Address=5 -> Mem_WE at 5, next load WB_Data=16'h00AB, WB_Out=1.
- Push 16'h1234 from reset -> written at 12'hFFF, SP=12'hFFE; pop -> WB_Data=16'h1234, SP=12'hFFF.
- CALL push PC=32'h0001_0020 -> hi 16'h0001 at FFF, lo 16'h0020 at FFE, Stall=1 for exactly 1 cycle, SP=FFD.
- INT push (Stack_Flags=1, Final_Flags=3'b101) then RTI pop -> 3 beats each, Stall 2 cycles, MEM_Stack_Flags pulse with Flags_From_Memory=3'b101, PC_Load pulse with pushed PC, SP back to FFF.
- SP wrap: 4096 single pushes from reset -> SP returns to 12'hFFF, no error.
- rst asserted during BEAT1 of a CALL -> Stall drops immediately, SP=FFF, no PC_Load.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types and helpers for the memory stage.
//   state_t    : multi-beat sequencer states (IDLE, BEAT1, BEAT2)
//   op_t       : memory operation class decoded from EX/MEM control bits
//   flags_word : layout of the flags word pushed on INT ({13'b0, NF, CF, ZF})
package memory_stage_pkg;

    localparam int DEFAULT_ADDR_W  = 12;
    localparam int DEFAULT_SP_INIT = 2**DEFAULT_ADDR_W - 1;
    localparam int FLAGS_W         = 3;
    localparam int FLAGS_PAD_W     = 16 - FLAGS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_t;

    // MR&MW together without SP resolves to a store.
    function automatic op_t classify_op(input logic sp, input logic spop,
                                        input logic mr, input logic mw);
        op_t op;
        op = OP_NONE;
        if (sp) begin
            if (!spop && mw)     op = OP_PUSH;
            else if (spop && mr) op = OP_POP;
        end else begin
            if (mw)      op = OP_STORE;
            else if (mr) op = OP_LOAD;
        end
        return op;
    endfunction

    function automatic logic [15:0] flags_word(input logic [FLAGS_W-1:0] f);
        return {{FLAGS_PAD_W{1'b0}}, f};
    endfunction

endpackage

// File: rtl/memory_stage_sp_register.sv
// sp_register: stack pointer storage for the memory stage.
//   clk, rst     : clock, asynchronous active-low reset (SP <- SP_INIT)
//   inc, dec     : step SP up/down by one this cycle (dec wins if both)
//   sp           : current stack pointer
//   sp_plus1     : sp + 1, the address a pop reads
// Arithmetic wraps modulo 2**ADDR_W.
module sp_register
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W  = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1
);

    assign sp_plus1 = sp + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     sp <= SP_INIT;
        else if (dec) sp <= sp - ADDR_W'(1);
        else if (inc) sp <= sp_plus1;
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-memory load/store, stack push/pop and multi-beat
// PC/flags save-restore for CALL/INT/RET/RTI.
//   Inputs  : EX/MEM fields (Data, Address, MR, MW, WB, SP, SPOP, JWSP,
//             Stack_PC, Stack_Flags, WB_Address, Final_Flags), Mem_RData
//   Memory  : Mem_Addr, Mem_WData, Mem_WE (combinational; write at edge)
//   Control : Stall freezes IF..EX/MEM while a burst is in progress
//   MEM/WB  : WB_Out, WB_Address_Out, WB_Data (registered)
//   Restore : PC_From_Memory/PC_Load, Flags_From_Memory/MEM_Stack_Flags
//   Debug   : SP_Value
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W  = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Data,
    input  logic [31:0]       Address,
    input  logic              MR,
    input  logic              MW,
    input  logic              WB,
    input  logic              SP,
    input  logic              SPOP,
    input  logic              JWSP,
    input  logic              Stack_PC,
    input  logic              Stack_Flags,
    input  logic [2:0]        WB_Address,
    input  logic [2:0]        Final_Flags,
    input  logic [15:0]       Mem_RData,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [15:0]       Mem_WData,
    output logic              Mem_WE,
    output logic              Stall,
    output logic              WB_Out,
    output logic [2:0]        WB_Address_Out,
    output logic [15:0]       WB_Data,
    output logic [31:0]       PC_From_Memory,
    output logic              PC_Load,
    output logic [2:0]        Flags_From_Memory,
    output logic              MEM_Stack_Flags,
    output logic [ADDR_W-1:0] SP_Value
);

    op_t               op;
    state_t            state, next_state;
    logic              burst_start;
    logic              sp_inc, sp_dec;
    logic [ADDR_W-1:0] sp_q, sp_p1;

    // Burst command latched at beat 0; later beats ignore EX/MEM.
    logic              lat_pop;
    logic              lat_flags;
    logic [15:0]       lat_pc_lo;
    logic [2:0]        lat_ff;
    logic [15:0]       pc_lo;

    // Pop-side capture strobes for the current beat.
    logic              cap_flags, cap_lo, cap_hi;

    // JWSP is part of the EX/MEM bundle but carries no meaning in this stage.
    logic              unused_inputs;
    assign unused_inputs = ^{JWSP, Address[31:ADDR_W]};

    assign op          = classify_op(SP, SPOP, MR, MW);
    assign burst_start = Stack_PC && (op == OP_PUSH || op == OP_POP);
    assign SP_Value    = sp_q;

    sp_register #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp_q),
        .sp_plus1 (sp_p1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Beat sequencing. Push order: PC hi, PC lo, flags.
    // Pop order is the reverse: flags (optional), PC lo, PC hi.
    always_comb begin
        next_state = state;
        Mem_Addr   = Address[ADDR_W-1:0];
        Mem_WData  = Data[15:0];
        Mem_WE     = 1'b0;
        Stall      = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        cap_flags  = 1'b0;
        cap_lo     = 1'b0;
        cap_hi     = 1'b0;
        case (state)
            IDLE: begin
                if (burst_start) begin
                    Stall      = 1'b1;
                    next_state = BEAT1;
                    if (op == OP_PUSH) begin
                        Mem_Addr  = sp_q;
                        Mem_WData = Data[31:16];
                        Mem_WE    = 1'b1;
                        sp_dec    = 1'b1;
                    end else begin
                        Mem_Addr  = sp_p1;
                        sp_inc    = 1'b1;
                        cap_flags = Stack_Flags;
                        cap_lo    = !Stack_Flags;
                    end
                end else begin
                    case (op)
                        OP_PUSH: begin
                            Mem_Addr = sp_q;
                            Mem_WE   = 1'b1;
                            sp_dec   = 1'b1;
                        end
                        OP_POP: begin
                            Mem_Addr = sp_p1;
                            sp_inc   = 1'b1;
                        end
                        OP_STORE: Mem_WE = 1'b1;
                        default: ;
                    endcase
                end
            end
            BEAT1: begin
                Stall      = lat_flags;
                next_state = lat_flags ? BEAT2 : IDLE;
                if (!lat_pop) begin
                    Mem_Addr  = sp_q;
                    Mem_WData = lat_pc_lo;
                    Mem_WE    = 1'b1;
                    sp_dec    = 1'b1;
                end else begin
                    Mem_Addr  = sp_p1;
                    sp_inc    = 1'b1;
                    cap_lo    = lat_flags;
                    cap_hi    = !lat_flags;
                end
            end
            BEAT2: begin
                next_state = IDLE;
                if (!lat_pop) begin
                    Mem_Addr  = sp_q;
                    Mem_WData = flags_word(lat_ff);
                    Mem_WE    = 1'b1;
                    sp_dec    = 1'b1;
                end else begin
                    Mem_Addr  = sp_p1;
                    sp_inc    = 1'b1;
                    cap_hi    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_pop   <= 1'b0;
            lat_flags <= 1'b0;
            lat_pc_lo <= '0;
            lat_ff    <= '0;
            pc_lo     <= '0;
        end else begin
            if (state == IDLE && burst_start) begin
                lat_pop   <= (op == OP_POP);
                lat_flags <= Stack_Flags;
                lat_pc_lo <= Data[15:0];
                lat_ff    <= Final_Flags;
            end
            if (cap_lo) pc_lo <= Mem_RData;
        end
    end

    // MEM/WB buffer and restore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_Out            <= 1'b0;
            WB_Address_Out    <= '0;
            WB_Data           <= '0;
            PC_From_Memory    <= '0;
            PC_Load           <= 1'b0;
            Flags_From_Memory <= '0;
            MEM_Stack_Flags   <= 1'b0;
        end else begin
            WB_Out         <= (state == IDLE) && WB && !Stack_PC;
            WB_Address_Out <= WB_Address;
            WB_Data        <= (state == IDLE && !Stack_PC && (op == OP_LOAD || op == OP_POP))
                              ? Mem_RData : Data[15:0];
            PC_Load         <= cap_hi;
            MEM_Stack_Flags <= cap_flags;
            if (cap_hi)    PC_From_Memory    <= {Mem_RData, pc_lo};
            if (cap_flags) Flags_From_Memory <= Mem_RData[2:0];
        end
    end

endmodule
